aim65_boot_sequencer: RTL

Controller that sequences reset, CPU clock-enable and live configuration for the aim65 core inside the MiSTer emu wrapper. It merges the OSD reset, user-button reset and power-on reset into one timed core reset. It applies OSD changes to extended-ROM select and input mode only through a controlled reset, so the core never sees configuration change while running. It gates the 1 MHz CPU clock-enable so the CPU is frozen whenever the sequencer is not in RUN.

---
 rtl/aim65_boot_sequencer_if.sv | 23 ++
 rtl/aim65_boot_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/aim65_boot_sequencer_if.sv
// Request/status bundle between the MiSTer emu wrapper and the aim65 boot sequencer.
interface aim65_boot_sequencer_if;
  logic       sw_reset;
  logic       btn_reset;
  logic [1:0] ext_sel_req;
  logic       kbd_not_tty_req;
  logic       core_reset;
  logic       cpu_ce;
  logic [1:0] ext_sel_active;
  logic       kbd_not_tty_active;
  logic       seq_busy;
  logic [7:0] reset_count;

  modport master (
    output sw_reset, btn_reset, ext_sel_req, kbd_not_tty_req,
    input  core_reset, cpu_ce, ext_sel_active, kbd_not_tty_active, seq_busy, reset_count
  );

  modport slave (
    input  sw_reset, btn_reset, ext_sel_req, kbd_not_tty_req,
    output core_reset, cpu_ce, ext_sel_active, kbd_not_tty_active, seq_busy, reset_count
  );
endinterface

// File: rtl/aim65_boot_sequencer.sv
// Merges OSD/button/power-on resets into one timed core reset, applies config only
// through a reset, and gates the 1 MHz CPU clock-enable outside RUN.
module aim65_boot_sequencer #(
  parameter int unsigned HOLD_CYCLES   = 100,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned CPU_DIV       = 50
) (
  input logic                    clk_sys,
  input logic                    reset_n,
  aim65_boot_sequencer_if.slave  bus
);
  localparam int unsigned HW = $clog2(HOLD_CYCLES);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned DW = $clog2(CPU_DIV);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(CPU_DIV - 1);

  typedef enum logic [1:0] {HOLD, RUN, SETTLE} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] settle_cnt;
  logic [DW-1:0] div_cnt;
  logic          sw_meta, sw_sync, btn_meta, btn_sync;
  logic [1:0]    ext_q;
  logic          kbd_q;
  logic [2:0]    last_req;
  logic [7:0]    rst_cnt;
  logic          req;
  logic [2:0]    cfg_req;
  logic [2:0]    cfg_act;

  assign req     = sw_sync | btn_sync;
  assign cfg_req = {bus.ext_sel_req, bus.kbd_not_tty_req};
  assign cfg_act = {ext_q, kbd_q};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      settle_cnt <= '0;
      div_cnt    <= '0;
      sw_meta    <= 1'b0;
      sw_sync    <= 1'b0;
      btn_meta   <= 1'b0;
      btn_sync   <= 1'b0;
      ext_q      <= '0;
      kbd_q      <= 1'b1;
      last_req   <= '0;
      rst_cnt    <= '0;
    end else begin
      sw_meta  <= bus.sw_reset;
      sw_sync  <= sw_meta;
      btn_meta <= bus.btn_reset;
      btn_sync <= btn_meta;
      case (state)
        HOLD: begin
          div_cnt <= '0;
          if (hold_cnt == HOLD_LAST) begin
            // Counter parks at its last value so a held request stretches the reset.
            if (!req) begin
              state <= RUN;
              ext_q <= bus.ext_sel_req;
              kbd_q <= bus.kbd_not_tty_req;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (req) begin
            state    <= HOLD;
            hold_cnt <= '0;
            div_cnt  <= '0;
            if (rst_cnt != 8'hFF) rst_cnt <= rst_cnt + 8'd1;
          end else if (cfg_req != cfg_act) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            last_req   <= cfg_req;
            div_cnt    <= '0;
          end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
          end
        end
        SETTLE: begin
          div_cnt <= '0;
          if (req) begin
            state    <= HOLD;
            hold_cnt <= '0;
            if (rst_cnt != 8'hFF) rst_cnt <= rst_cnt + 8'd1;
          end else if (cfg_req == cfg_act) begin
            state <= RUN;
          end else if (cfg_req != last_req) begin
            last_req   <= cfg_req;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state    <= HOLD;
            hold_cnt <= '0;
            if (rst_cnt != 8'hFF) rst_cnt <= rst_cnt + 8'd1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

  assign bus.core_reset         = (state == HOLD);
  assign bus.seq_busy           = (state != RUN);
  assign bus.cpu_ce             = (state == RUN) && (div_cnt == DIV_LAST);
  assign bus.ext_sel_active     = ext_q;
  assign bus.kbd_not_tty_active = kbd_q;
  assign bus.reset_count        = rst_cnt;
endmodule
